// File: rtl/pe_dbuf_agu_nd.sv
// Data-buffer address generator for one PE: walks a (row_lim+1)x(col_lim+1) tile window
// in forward, flipped or column-major order. Optional stall counter: PE_DBUF_AGU_STALL_CNT_EN.
module pe_dbuf_agu_nd #(
  parameter int ADDR_W     = 9,
  parameter int IDX_W      = 4,
  parameter int CNT_W      = 4,
  parameter int TILE_SHIFT = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [1:0]        mode,
  input  logic [IDX_W-1:0]  idx,
  input  logic [CNT_W-1:0]  row_lim,
  input  logic [CNT_W-1:0]  col_lim,
  output logic              busy,
  output logic [ADDR_W-1:0] addr,
  output logic              addr_vld,
  input  logic              addr_rdy,
  output logic              addr_last,
  output logic              done
`ifdef PE_DBUF_AGU_STALL_CNT_EN
  ,
  output logic [15:0]       stall_cnt
`endif
);

  localparam int OFF_W = 2 * CNT_W + 1;

  typedef enum logic [1:0] {
    M_FWD   = 2'd0,
    M_BWD   = 2'd1,
    M_TRANS = 2'd2,
    M_RSVD  = 2'd3
  } mode_t;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t             state, n_state;
  mode_t              mode_q, n_mode;
  logic [IDX_W-1:0]   idx_q, n_idx;
  logic [CNT_W-1:0]   rl_q, n_rl;
  logic [CNT_W-1:0]   cl_q, n_cl;
  logic [CNT_W-1:0]   r, n_r;
  logic [CNT_W-1:0]   c, n_c;
  logic               load;
  logic               accept;
  logic               fin;

  logic [CNT_W:0]            width_n;
  logic [CNT_W-1:0]          row_sel;
  logic [CNT_W-1:0]          col_sel;
  logic [OFF_W-1:0]          off;
  logic [IDX_W+TILE_SHIFT-1:0] base;
  logic [ADDR_W-1:0]         addr_n;

  assign busy     = (state == RUN);
  assign addr_vld = (state == RUN);

  // Next config/counters; 'load' marks cycles where a new address must be registered.
  always_comb begin
    n_state = state;
    n_mode  = mode_q;
    n_idx   = idx_q;
    n_rl    = rl_q;
    n_cl    = cl_q;
    n_r     = r;
    n_c     = c;
    load    = 1'b0;
    accept  = 1'b0;
    fin     = 1'b0;
    case (state)
      IDLE: begin
        if (start && (mode != M_RSVD)) begin
          n_mode  = mode_t'(mode);
          n_idx   = idx;
          n_rl    = row_lim;
          n_cl    = col_lim;
          n_r     = '0;
          n_c     = '0;
          load    = 1'b1;
          accept  = 1'b1;
          n_state = RUN;
        end
      end
      RUN: begin
        if (addr_rdy) begin
          if (addr_last) begin
            fin     = 1'b1;
            n_state = IDLE;
          end else begin
            load = 1'b1;
            if (mode_q == M_TRANS) begin
              if (r == rl_q) begin
                n_r = '0;
                n_c = c + 1'b1;
              end else begin
                n_r = r + 1'b1;
              end
            end else begin
              if (c == cl_q) begin
                n_c = '0;
                n_r = r + 1'b1;
              end else begin
                n_c = c + 1'b1;
              end
            end
          end
        end
      end
      default: n_state = IDLE;
    endcase
  end

  // Address of the next element; the flipped walk mirrors both row and column.
  always_comb begin
    width_n = {1'b0, n_cl} + 1'b1;
    row_sel = (n_mode == M_BWD) ? (n_rl - n_r) : n_r;
    col_sel = (n_mode == M_BWD) ? (n_cl - n_c) : n_c;
    off     = OFF_W'(row_sel) * OFF_W'(width_n) + OFF_W'(col_sel);
    base    = {n_idx, {TILE_SHIFT{1'b0}}};
    addr_n  = ADDR_W'(base) + ADDR_W'(off);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      mode_q    <= M_FWD;
      idx_q     <= '0;
      rl_q      <= '0;
      cl_q      <= '0;
      r         <= '0;
      c         <= '0;
      addr      <= '0;
      addr_last <= 1'b0;
      done      <= 1'b0;
    end else begin
      state  <= n_state;
      mode_q <= n_mode;
      idx_q  <= n_idx;
      rl_q   <= n_rl;
      cl_q   <= n_cl;
      r      <= n_r;
      c      <= n_c;
      done   <= fin;
      if (load) begin
        addr      <= addr_n;
        addr_last <= (n_r == n_rl) && (n_c == n_cl);
      end else if (fin) begin
        addr_last <= 1'b0;
      end
    end
  end

`ifdef PE_DBUF_AGU_STALL_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (accept) begin
      stall_cnt <= '0;
    end else if ((state == RUN) && !addr_rdy && (stall_cnt != 16'hFFFF)) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pe_dbuf_agu_nd.sv
// Directed self-checking bench for pe_dbuf_agu_nd; honours PE_DBUF_AGU_STALL_CNT_EN.
module tb_pe_dbuf_agu_nd;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [1:0] mode;
  logic [3:0] idx;
  logic [3:0] row_lim;
  logic [3:0] col_lim;
  logic       busy;
  logic [8:0] addr;
  logic       addr_vld;
  logic       addr_rdy;
  logic       addr_last;
  logic       done;
`ifdef PE_DBUF_AGU_STALL_CNT_EN
  logic [15:0] stall_cnt;
`endif

  int checks = 0;
  int errors = 0;

  pe_dbuf_agu_nd #(
    .ADDR_W(9), .IDX_W(4), .CNT_W(4), .TILE_SHIFT(5)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .idx(idx),
    .row_lim(row_lim), .col_lim(col_lim), .busy(busy), .addr(addr),
    .addr_vld(addr_vld), .addr_rdy(addr_rdy), .addr_last(addr_last), .done(done)
`ifdef PE_DBUF_AGU_STALL_CNT_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Advance one clock and settle just after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [1:0] m, input logic [3:0] i,
                          input logic [3:0] rl, input logic [3:0] cl);
    mode = m; idx = i; row_lim = rl; col_lim = cl; start = 1'b1;
    step();
    start = 1'b0;
    mode = 2'd3; idx = 4'hA; row_lim = 4'h5; col_lim = 4'h6;
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if ({busy, addr_vld, addr_last, done} !== 4'b0000 || addr !== 9'd0) begin
      errors++;
      $display("[TB] FAIL reset flags=%b addr=%0d expected flags=0000 addr=0",
               {busy, addr_vld, addr_last, done}, addr);
    end
    step();
    rst = 1'b0;
    step();
  endtask

  task automatic test_fwd();
    addr_rdy = 1'b1;
    do_start(2'd0, 4'd2, 4'd3, 4'd2);
    for (int i = 0; i < 12; i++) begin
      checks++;
      if (addr !== 9'(64 + i) || {busy, addr_vld, addr_last} !== {2'b11, i == 11}) begin
        errors++;
        $display("[TB] FAIL fwd[%0d] addr=%0d bvl=%b expected addr=%0d bvl=%b",
                 i, addr, {busy, addr_vld, addr_last}, 64 + i, {2'b11, i == 11});
      end
      step();
    end
    checks++;
    if ({busy, addr_vld, addr_last, done} !== 4'b0001 || addr !== 9'd75) begin
      errors++;
      $display("[TB] FAIL fwd_done flags=%b addr=%0d expected flags=0001 addr=75",
               {busy, addr_vld, addr_last, done}, addr);
    end
    step();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL fwd_after done=%b busy=%b expected 0 0", done, busy);
    end
  endtask

  task automatic test_bwd();
    logic [8:0] exp_a [6] = '{9'd5, 9'd4, 9'd3, 9'd2, 9'd1, 9'd0};
    addr_rdy = 1'b1;
    do_start(2'd1, 4'd0, 4'd1, 4'd2);
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (addr !== exp_a[i] || addr_vld !== 1'b1 || addr_last !== (i == 5)) begin
        errors++;
        $display("[TB] FAIL bwd[%0d] addr=%0d last=%b expected addr=%0d last=%b",
                 i, addr, addr_last, exp_a[i], i == 5);
      end
      step();
    end
    checks++;
    if (done !== 1'b1 || addr_vld !== 1'b0) begin
      errors++;
      $display("[TB] FAIL bwd_done done=%b vld=%b expected 1 0", done, addr_vld);
    end
    step();
  endtask

  task automatic test_trans();
    logic [8:0] exp_a [6] = '{9'd32, 9'd34, 9'd36, 9'd33, 9'd35, 9'd37};
    addr_rdy = 1'b1;
    do_start(2'd2, 4'd1, 4'd2, 4'd1);
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (addr !== exp_a[i] || addr_vld !== 1'b1 || addr_last !== (i == 5)) begin
        errors++;
        $display("[TB] FAIL trans[%0d] addr=%0d last=%b expected addr=%0d last=%b",
                 i, addr, addr_last, exp_a[i], i == 5);
      end
      step();
    end
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("[TB] FAIL trans_done done=%b expected 1", done);
    end
    step();
  endtask

  task automatic test_back_pressure();
    logic       rdy_seq [7] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    logic [8:0] exp_a   [7] = '{9'd0, 9'd0, 9'd1, 9'd1, 9'd1, 9'd2, 9'd3};
    int hs_count = 0;
    int done_count = 0;
    addr_rdy = 1'b0;
    do_start(2'd0, 4'd0, 4'd1, 4'd1);
    for (int k = 0; k < 9; k++) begin
      addr_rdy = (k < 7) ? rdy_seq[k] : 1'b1;
      start = (k == 2);
      if (k == 2) begin
        mode = 2'd2; idx = 4'd5; row_lim = 4'd3; col_lim = 4'd3;
      end
      if (k < 7) begin
        checks++;
        if (addr !== exp_a[k] || addr_vld !== 1'b1 || addr_last !== (k == 6)) begin
          errors++;
          $display("[TB] FAIL bp[%0d] addr=%0d vld=%b last=%b expected addr=%0d vld=1 last=%b",
                   k, addr, addr_vld, addr_last, exp_a[k], k == 6);
        end
      end
      if (addr_vld && addr_rdy) hs_count++;
      if (done) done_count++;
      step();
      start = 1'b0;
    end
    checks++;
    if (hs_count !== 4) begin
      errors++;
      $display("[TB] FAIL bp_handshakes got=%0d expected 4", hs_count);
    end
    checks++;
    if (done_count !== 1) begin
      errors++;
      $display("[TB] FAIL bp_done_pulses got=%0d expected 1", done_count);
    end
`ifdef PE_DBUF_AGU_STALL_CNT_EN
    checks++;
    if (stall_cnt !== 16'd3) begin
      errors++;
      $display("[TB] FAIL bp_stall_cnt got=%0d expected 3", stall_cnt);
    end
`endif
    addr_rdy = 1'b1;
  endtask

  task automatic test_boundaries();
    addr_rdy = 1'b1;
    do_start(2'd0, 4'd3, 4'd0, 4'd0);
    checks++;
    if (addr !== 9'd96 || {addr_vld, addr_last} !== 2'b11) begin
      errors++;
      $display("[TB] FAIL single addr=%0d vl=%b expected addr=96 vl=11", addr, {addr_vld, addr_last});
    end
    step();
    checks++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL single_done done=%b busy=%b expected 1 0", done, busy);
    end
    step();
    do_start(2'd3, 4'd1, 4'd1, 4'd1);
    checks++;
    if ({busy, addr_vld, done} !== 3'b000 || addr !== 9'd96) begin
      errors++;
      $display("[TB] FAIL rsvd_mode flags=%b addr=%0d expected flags=000 addr=96",
               {busy, addr_vld, done}, addr);
    end
    step();
    do_start(2'd0, 4'd15, 4'd15, 4'd15);
    for (int i = 0; i < 256; i++) begin
      checks++;
      if (addr !== 9'((480 + i) % 512) || addr_last !== (i == 255)) begin
        errors++;
        $display("[TB] FAIL wrap[%0d] addr=%0d last=%b expected addr=%0d last=%b",
                 i, addr, addr_last, (480 + i) % 512, i == 255);
      end
      step();
    end
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("[TB] FAIL wrap_done done=%b expected 1", done);
    end
    step();
  endtask

  task automatic test_async_reset();
    addr_rdy = 1'b1;
    do_start(2'd0, 4'd1, 4'd3, 4'd3);
    step();
    step();
    #3;
    rst = 1'b1;
    #1;
    checks++;
    if ({busy, addr_vld, addr_last, done} !== 4'b0000 || addr !== 9'd0) begin
      errors++;
      $display("[TB] FAIL async_rst flags=%b addr=%0d expected flags=0000 addr=0",
               {busy, addr_vld, addr_last, done}, addr);
    end
    step();
    rst = 1'b0;
    step();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL async_no_done done=%b busy=%b expected 0 0", done, busy);
    end
    do_start(2'd0, 4'd1, 4'd1, 4'd1);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (addr !== 9'(32 + i) || addr_last !== (i == 3)) begin
        errors++;
        $display("[TB] FAIL restart[%0d] addr=%0d last=%b expected addr=%0d last=%b",
                 i, addr, addr_last, 32 + i, i == 3);
      end
      step();
    end
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("[TB] FAIL restart_done done=%b expected 1", done);
    end
    step();
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; mode = 2'd0; idx = '0;
    row_lim = '0; col_lim = '0; addr_rdy = 1'b0;
    test_reset();
    test_fwd();
    test_bwd();
    test_trans();
    test_back_pressure();
    test_boundaries();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pe_dbuf_agu_nd.md
Name: pe_dbuf_agu_nd

Overview:
- Parametrised data-buffer address generator for one PE in the CNN training datapath; successor of the fixed 4-row forward-only AGU.
- On `start`, latches a tile index, row/column limits and a traversal mode.
- Emits one buffer read address per accepted handshake over a (row_lim+1) x (col_lim+1) window, then pulses `done`.
- Supports forward, 180-degree-flipped (backward conv) and column-major (weight-gradient) traversal, with valid/ready back-pressure.

Parameters:
- ADDR_W, 9: data buffer address width.
- IDX_W, 4: tile index width (same as global IDX_W).
- CNT_W, 4: row/column counter width; max window 2^CNT_W x 2^CNT_W.
- TILE_SHIFT, 5: base address = idx << TILE_SHIFT.

Ports:
- clk, input, 1: single clock.
- rst, input, 1: asynchronous active-high reset.
- start, input, 1: one-cycle request; samples the config inputs below.
- mode, input, 2: 0 FWD, 1 BWD, 2 TRANS, 3 reserved.
- idx, input, IDX_W: tile index.
- row_lim, input, CNT_W: last row index (rows = row_lim+1).
- col_lim, input, CNT_W: last column index (cols = col_lim+1).
- busy, output, 1: high from the cycle after an accepted start until the final handshake.
- addr, output, ADDR_W: current read address.
- addr_vld, output, 1: addr valid.
- addr_rdy, input, 1: consumer accepts addr.
- addr_last, output, 1: qualifies the final address of the window.
- done, output, 1: one-cycle pulse the cycle after the final handshake.

Behaviour:
- Clock and reset: one clock `clk`; reset `rst` is asynchronous and active-high.
- Reset values: all outputs 0; state IDLE; counters 0; latched config 0.
- State IDLE:
  - start=1 with mode!=3: latch mode/idx/row_lim/col_lim, r=0, c=0, go to RUN.
  - start=1 with mode=3: ignored, stay IDLE, no outputs change.
- State RUN:
  - addr_vld=1 and busy=1. The first address is valid the cycle after start (latency 1).
  - A handshake is addr_vld && addr_rdy. Counters advance only on a handshake; addr, addr_last and the counters are held while addr_rdy=0.
- Loop order:
  - FWD and BWD: c is the inner loop (0..col_lim); r increments when c wraps.
  - TRANS: r is the inner loop (0..row_lim); c increments when r wraps.
- Offset calculation, with W = col_lim+1:
  - FWD/TRANS: off = r*W + c.
  - BWD: off = (row_lim-r)*W + (col_lim-c).
- Width rules:
  - off is computed at 2*CNT_W+1 bits.
  - addr = ((idx << TILE_SHIFT) + off) truncated to ADDR_W (modulo wrap, no error).
  - addr is registered and updated in the same cycle as the counters.
- addr_last=1 exactly when r==row_lim && c==col_lim (for every mode, the final emitted element).
- Handshake with addr_last=1: next cycle addr_vld=0, busy=0, addr_last=0, done=1 for one cycle; state returns to IDLE, and addr holds its last value.
- A start in the same cycle as the final handshake is ignored; start must come in IDLE, so the earliest restart is the done cycle.
- start while RUN: ignored. Latched config and counters are unaffected.
- Degenerate window: row_lim=0, col_lim=0 gives a single address with addr_last=1 on the first valid.
- Config inputs are don't-care except in the start cycle.
- rst mid-RUN: immediate return to IDLE; all outputs 0; no done pulse.

Optional Feature:
- Macro: PE_DBUF_AGU_STALL_CNT_EN.
- Defined:
  - Adds output `stall_cnt`, 16 bits.
  - Cleared on an accepted start.
  - Increments each cycle with addr_vld=1 && addr_rdy=0; saturates at 16'hFFFF.
  - Holds its value in IDLE until the next start. Reset value 0.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- FWD basic: mode=0, idx=2, row_lim=3, col_lim=2, addr_rdy=1 -> addr 64,65,...,75 on 12 consecutive cycles from the cycle after start; addr_last on 75; done the next cycle; busy low after.
- BWD flip: mode=1, idx=0, row_lim=1, col_lim=2 -> addr 5,4,3,2,1,0; addr_last on 0.
- TRANS: mode=2, idx=1, row_lim=2, col_lim=1 -> addr 32,34,36,33,35,37; addr_last on 37.
- Back-pressure and ignored start: FWD 2x2 with addr_rdy toggling 0,1,0,0,1,1,1 and a start pulse mid-run -> addr stable while rdy=0; exactly 4 handshakes (0,1,2,3); one done; second start has no effect. With PE_DBUF_AGU_STALL_CNT_EN, stall_cnt=3.
- Boundaries: row_lim=col_lim=0 -> one address with addr_last on the first valid. mode=3 start -> busy stays 0. idx=15, ADDR_W=9 with a large window -> addr wraps modulo 512.
- Async reset: assert rst mid-RUN between clock edges -> outputs 0 immediately; no done; a new start after release runs cleanly from r=c=0.
